batch_scheduler: RTL and testbench

Parametrised next-generation host-to-NoC work scheduler, sitting between the PCI streaming interface and the NoC injection port at the home node. It stamps each host payload with a sequence number and a destination PE and issues packets in configurable batches, round-robin over an enable mask that skips the home node. It caps outstanding work by a credit limit and returns results to the host strictly in issue order through an internal reorder buffer.

---
 rtl/sched_pkg.sv | 39 +++
 rtl/sched_rob.sv | 60 ++++++
 rtl/batch_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_batch_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared helpers for batch_scheduler: derived widths, packet field layout, mesh indexing.
package sched_pkg;

    // Width of an index/coordinate field, never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    // Linear PE index used by the enable mask: y*X+x.
    function automatic int unsigned xy_idx(input int unsigned x, input int unsigned y,
                                           input int unsigned nx);
        return y * nx + x;
    endfunction

    // Packet layout {payload, seq, y, x}, x in the LSBs.
    function automatic int unsigned off_x();
        return 0;
    endfunction

    function automatic int unsigned off_y(input int unsigned xw);
        return xw;
    endfunction

    function automatic int unsigned off_seq(input int unsigned xw, input int unsigned yw);
        return xw + yw;
    endfunction

    function automatic int unsigned off_data(input int unsigned xw, input int unsigned yw,
                                             input int unsigned pw);
        return xw + yw + pw;
    endfunction

    function automatic int unsigned total_w(input int unsigned dw, input int unsigned pw,
                                            input int unsigned yw, input int unsigned xw);
        return dw + pw + yw + xw;
    endfunction

endpackage

// File: rtl/sched_rob.sv
// Reorder buffer: returned payloads land by sequence number and leave to the host in issue order.
module sched_rob
    import sched_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PCK_W  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wr_en,
    input  logic [PCK_W-1:0]  i_wr_seq,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_valid_pci,
    output logic [DATA_W-1:0] o_data_pci,
    input  logic              i_ready_pci
);

    localparam int unsigned DEPTH = 1 << PCK_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vbits;
    logic [PCK_W-1:0]  r_rd_seq;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_pop;

    assign w_pop       = r_vbits[r_rd_seq] & (!r_valid | i_ready_pci);
    assign o_valid_pci = r_valid;
    assign o_data_pci  = r_data;

    // Payload storage; contents are qualified by r_vbits so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_seq] <= i_wr_data;
        end
    end

    // Valid bits, head pointer and host egress register; a pop clear overrides a same-slot set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vbits  <= '0;
            r_rd_seq <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (i_wr_en) begin
                r_vbits[i_wr_seq] <= 1'b1;
            end
            if (w_pop) begin
                r_vbits[r_rd_seq] <= 1'b0;
                r_data            <= r_mem[r_rd_seq];
                r_valid           <= 1'b1;
                r_rd_seq          <= r_rd_seq + PCK_W'(1);
            end else if (i_ready_pci) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/batch_scheduler.sv
// Host-to-NoC batch scheduler: sequence stamping, round-robin batched destinations,
// credit cap and in-order result return. Optional statistics counters under SCHED_STATS_EN.
module batch_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned X            = 2,
    parameter int unsigned Y            = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PCK_W        = 5,
    parameter int unsigned BATCH        = 8,
    parameter int unsigned HOME_X       = 0,
    parameter int unsigned HOME_Y       = 0,
    parameter int unsigned MAX_INFLIGHT = 16 * (X * Y - 1)
) (
    input  logic                                                clk,
    input  logic                                                rstn,
    input  logic                                                i_valid_pci,
    input  logic [DATA_W-1:0]                                   i_data_pci,
    output logic                                                o_ready_pci,
    output logic                                                o_valid_pci,
    output logic [DATA_W-1:0]                                   o_data_pci,
    input  logic                                                i_ready_pci,
    output logic                                                o_valid,
    output logic [total_w(DATA_W, PCK_W, clog2w(Y), clog2w(X))-1:0] o_data,
    input  logic                                                i_ready,
    input  logic                                                i_valid_pe,
    input  logic [total_w(DATA_W, PCK_W, clog2w(Y), clog2w(X))-1:0] i_data_pe,
    output logic                                                o_ready_pe,
    input  logic [X*Y-1:0]                                      i_pe_en
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                                         o_issued_cnt,
    output logic [31:0]                                         o_returned_cnt,
    output logic [31:0]                                         o_stall_cnt
`endif
);

    localparam int unsigned N        = X * Y;
    localparam int unsigned X_W      = clog2w(X);
    localparam int unsigned Y_W      = clog2w(Y);
    localparam int unsigned IDX_W    = clog2w(N);
    localparam int unsigned TOTAL_W  = total_w(DATA_W, PCK_W, Y_W, X_W);
    localparam int unsigned OFF_SEQ  = off_seq(X_W, Y_W);
    localparam int unsigned OFF_DATA = off_data(X_W, Y_W, PCK_W);
    localparam int unsigned DEPTH    = 1 << PCK_W;
    localparam int unsigned LIMIT    = (MAX_INFLIGHT < DEPTH) ? MAX_INFLIGHT : DEPTH;
    localparam int unsigned CNT_W    = $clog2(LIMIT + 1);
    localparam int unsigned BC_W     = clog2w(BATCH);
    localparam int unsigned SRCH_W   = 1 + Y_W + X_W;

    logic               r_valid;
    logic [TOTAL_W-1:0] r_data;
    logic [PCK_W-1:0]   r_wr_seq;
    logic [BC_W-1:0]    r_batch_cnt;
    logic [CNT_W-1:0]   r_count;
    logic [X_W-1:0]     r_dest_x;
    logic [Y_W-1:0]     r_dest_y;
    logic               r_dest_ok;

    logic [SRCH_W-1:0]  w_first;
    logic [SRCH_W-1:0]  w_next;
    logic               w_accept;
    logic               w_egress_hs;
    logic               w_batch_end;
    logic               w_ret_en;
    logic [TOTAL_W-1:0] w_pkt;
    logic               w_unused_coord;

    // Walk the y-major order starting after (sx,sy); return {hit, y, x} of the first usable PE.
    function automatic logic [SRCH_W-1:0] find_dest(input logic [N-1:0] en,
                                                    input int unsigned sx,
                                                    input int unsigned sy);
        int unsigned       cx;
        int unsigned       cy;
        logic              hit;
        logic [SRCH_W-1:0] res;
        cx  = sx;
        cy  = sy;
        hit = 1'b0;
        res = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cy == Y - 1) begin
                cy = 0;
                cx = (cx == X - 1) ? 32'd0 : cx + 32'd1;
            end else begin
                cy = cy + 32'd1;
            end
            if (!hit && en[IDX_W'(xy_idx(cx, cy, X))] && !(cx == HOME_X && cy == HOME_Y)) begin
                hit = 1'b1;
                res = {1'b1, Y_W'(cy), X_W'(cx)};
            end
        end
        return res;
    endfunction

    // Starting from the last position makes (0,0) the first candidate examined.
    assign w_first = find_dest(i_pe_en, X - 1, Y - 1);
    assign w_next  = find_dest(i_pe_en, 32'(r_dest_x), 32'(r_dest_y));

    assign o_ready_pci = rstn & (!r_valid | i_ready) & (r_count < CNT_W'(LIMIT)) & r_dest_ok;
    assign o_ready_pe  = rstn;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign w_accept    = i_valid_pci & o_ready_pci;
    assign w_egress_hs = o_valid_pci & i_ready_pci;
    assign w_batch_end = (r_batch_cnt == BC_W'(BATCH - 1));
    assign w_ret_en    = i_valid_pe & rstn;
    assign w_pkt       = {i_data_pci, r_wr_seq, r_dest_y, r_dest_x};

    // Coordinates of returning packets are not needed for reordering.
    assign w_unused_coord = ^i_data_pe[OFF_SEQ-1:0];

    // Issue register, sequence/batch tracking, destination advance and credit count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_wr_seq    <= '0;
            r_batch_cnt <= '0;
            r_count     <= '0;
            r_dest_ok   <= w_first[SRCH_W-1];
            r_dest_y    <= w_first[X_W+:Y_W];
            r_dest_x    <= w_first[X_W-1:0];
        end else begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_data   <= w_pkt;
                r_wr_seq <= r_wr_seq + PCK_W'(1);
                if (w_batch_end) begin
                    r_batch_cnt <= '0;
                    r_dest_ok   <= w_next[SRCH_W-1];
                    r_dest_y    <= w_next[X_W+:Y_W];
                    r_dest_x    <= w_next[X_W-1:0];
                end else begin
                    r_batch_cnt <= r_batch_cnt + BC_W'(1);
                end
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            // With no destination the scheduler idles at a boundary and keeps re-sampling the mask.
            if (!r_dest_ok) begin
                r_dest_ok <= w_first[SRCH_W-1];
                r_dest_y  <= w_first[X_W+:Y_W];
                r_dest_x  <= w_first[X_W-1:0];
            end
            case ({w_accept, w_egress_hs})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    sched_rob #(
        .DATA_W (DATA_W),
        .PCK_W  (PCK_W)
    ) u_rob (
        .clk         (clk),
        .rstn        (rstn),
        .i_wr_en     (w_ret_en),
        .i_wr_seq    (i_data_pe[OFF_SEQ+:PCK_W]),
        .i_wr_data   (i_data_pe[OFF_DATA+:DATA_W]),
        .o_valid_pci (o_valid_pci),
        .o_data_pci  (o_data_pci),
        .i_ready_pci (i_ready_pci)
    );

`ifdef SCHED_STATS_EN
    logic [31:0] r_issued_cnt;
    logic [31:0] r_returned_cnt;
    logic [31:0] r_stall_cnt;

    assign o_issued_cnt   = r_issued_cnt;
    assign o_returned_cnt = r_returned_cnt;
    assign o_stall_cnt    = r_stall_cnt;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_issued_cnt   <= '0;
            r_returned_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_accept && r_issued_cnt != '1) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
            if (w_ret_en && r_returned_cnt != '1) begin
                r_returned_cnt <= r_returned_cnt + 32'd1;
            end
            if (i_valid_pci && !o_ready_pci && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_batch_scheduler.sv
// Directed bench for batch_scheduler (X=Y=2, home (0,0), PCK_W=3, BATCH=2).
module tb_batch_scheduler;

    localparam int unsigned TW = 37;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid_pci;
    logic [31:0]   i_data_pci;
    logic          o_ready_pci;
    logic          o_valid_pci;
    logic [31:0]   o_data_pci;
    logic          i_ready_pci;
    logic          o_valid;
    logic [TW-1:0] o_data;
    logic          i_ready;
    logic          i_valid_pe;
    logic [TW-1:0] i_data_pe;
    logic          o_ready_pe;
    logic [3:0]    i_pe_en;

    int checks   = 0;
    int failures = 0;
    int acc;

    always #5 clk = ~clk;

    batch_scheduler #(
        .X      (2),
        .Y      (2),
        .DATA_W (32),
        .PCK_W  (3),
        .BATCH  (2),
        .HOME_X (0),
        .HOME_Y (0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid_pci (i_valid_pci),
        .i_data_pci  (i_data_pci),
        .o_ready_pci (o_ready_pci),
        .o_valid_pci (o_valid_pci),
        .o_data_pci  (o_data_pci),
        .i_ready_pci (i_ready_pci),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .i_valid_pe  (i_valid_pe),
        .i_data_pe   (i_data_pe),
        .o_ready_pe  (o_ready_pe),
        .i_pe_en     (i_pe_en)
    );

    function automatic logic [TW-1:0] mk(input logic [31:0] p, input logic [2:0] s,
                                         input logic y, input logic x);
        return {p, s, y, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic ord_x [6];
        logic ord_y [6];
        logic msk_x [6];
        logic msk_y [6];
        ord_x = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ord_y = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        msk_x = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        msk_y = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rstn = 1'b0; i_valid_pci = 1'b0; i_data_pci = '0; i_ready_pci = 1'b0;
        i_ready = 1'b0; i_valid_pe = 1'b0; i_data_pe = '0; i_pe_en = 4'hF;
        repeat (3) tick();
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_o_valid_pci", 64'(o_valid_pci), 64'd0);
        chk("rst_o_data_pci", 64'(o_data_pci), 64'd0);
        chk("rst_o_ready_pci", 64'(o_ready_pci), 64'd0);
        chk("rst_o_ready_pe", 64'(o_ready_pe), 64'd0);
        rstn = 1'b1;
        tick();
        chk("post_rst_ready_pci", 64'(o_ready_pci), 64'd1);
        chk("post_rst_ready_pe", 64'(o_ready_pe), 64'd1);

        // Destination order, one packet per cycle
        i_ready = 1'b1; i_valid_pci = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_data_pci = 32'hA0 + 32'(k);
            chk("ord_ready", 64'(o_ready_pci), 64'd1);
            tick();
            chk("ord_valid", 64'(o_valid), 64'd1);
            chk("ord_data", 64'(o_data), 64'(mk(32'hA0 + 32'(k), 3'(k), ord_y[k], ord_x[k])));
        end
        i_valid_pci = 1'b0;
        tick();
        chk("ord_idle", 64'(o_valid), 64'd0);

        // Out-of-order return 3,1,0,2
        i_ready_pci = 1'b1; i_valid_pe = 1'b1;
        i_data_pe = mk(32'hA3, 3'd3, 1'b1, 1'b1); tick();
        chk("ooo_wait3", 64'(o_valid_pci), 64'd0);
        i_data_pe = mk(32'hA1, 3'd1, 1'b1, 1'b0); tick();
        chk("ooo_wait1", 64'(o_valid_pci), 64'd0);
        i_data_pe = mk(32'hA0, 3'd0, 1'b1, 1'b0); tick();
        chk("ooo_lat1", 64'(o_valid_pci), 64'd0);
        i_data_pe = mk(32'hA2, 3'd2, 1'b0, 1'b1); tick();
        chk("ooo_lat2_valid", 64'(o_valid_pci), 64'd1);
        chk("ooo_data0", 64'(o_data_pci), 64'hA0);
        i_valid_pe = 1'b0;
        tick(); chk("ooo_data1", 64'(o_data_pci), 64'hA1);
        tick(); chk("ooo_data2", 64'(o_data_pci), 64'hA2);
        tick(); chk("ooo_data3", 64'(o_data_pci), 64'hA3);
        tick(); chk("ooo_drained", 64'(o_valid_pci), 64'd0);

        // NoC backpressure
        i_ready_pci = 1'b0;
        i_valid_pci = 1'b1; i_data_pci = 32'hD0;
        tick();
        chk("bp_issue", 64'(o_data), 64'(mk(32'hD0, 3'd6, 1'b1, 1'b0)));
        i_ready = 1'b0; i_data_pci = 32'hD1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_hold", 64'(o_data), 64'(mk(32'hD0, 3'd6, 1'b1, 1'b0)));
            chk("bp_ready_pci", 64'(o_ready_pci), 64'd0);
        end
        i_valid_pci = 1'b0; i_ready = 1'b1;
        tick();
        chk("bp_release", 64'(o_valid), 64'd0);

        // Host egress hold
        i_valid_pe = 1'b1; i_data_pe = mk(32'hA4, 3'd4, 1'b0, 1'b1); tick();
        i_data_pe = mk(32'hA5, 3'd5, 1'b0, 1'b1); tick();
        chk("eg_valid", 64'(o_valid_pci), 64'd1);
        chk("eg_data4", 64'(o_data_pci), 64'hA4);
        i_valid_pe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("eg_hold", 64'(o_data_pci), 64'hA4);
        end
        i_ready_pci = 1'b1;
        tick(); chk("eg_data5", 64'(o_data_pci), 64'hA5);
        tick(); chk("eg_drained", 64'(o_valid_pci), 64'd0);

        // Credit limit from a clean start
        rstn = 1'b0; tick(); rstn = 1'b1; tick();
        i_valid_pci = 1'b1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            i_data_pci = 32'hB0 + 32'(acc);
            if (o_ready_pci) acc++;
            tick();
        end
        chk("credit_accepts", 64'(acc), 64'd8);
        chk("credit_blocked", 64'(o_ready_pci), 64'd0);
        chk("credit_last", 64'(o_data), 64'(mk(32'hB7, 3'd7, 1'b1, 1'b0)));
        i_data_pci = 32'hC0;
        i_valid_pe = 1'b1; i_data_pe = mk(32'hB0, 3'd0, 1'b1, 1'b0); tick();
        chk("credit_still_blocked", 64'(o_ready_pci), 64'd0);
        i_valid_pe = 1'b0; tick();
        chk("credit_pop_valid", 64'(o_valid_pci), 64'd1);
        chk("credit_pop_data", 64'(o_data_pci), 64'hB0);
        chk("credit_pop_pending", 64'(o_ready_pci), 64'd0);
        tick();
        chk("credit_freed", 64'(o_ready_pci), 64'd1);
        tick();
        chk("credit_reissue", 64'(o_data), 64'(mk(32'hC0, 3'd0, 1'b0, 1'b1)));
        chk("credit_reblocked", 64'(o_ready_pci), 64'd0);
        i_valid_pci = 1'b0;

        // Mask changes take effect at batch boundaries
        rstn = 1'b0; tick(); rstn = 1'b1; tick();
        i_valid_pci = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) i_pe_en = 4'b0100;
            if (k == 5) i_pe_en = 4'b0001;
            i_data_pci = 32'hE0 + 32'(k);
            chk("mask_ready", 64'(o_ready_pci), 64'd1);
            tick();
            chk("mask_data", 64'(o_data), 64'(mk(32'hE0 + 32'(k), 3'(k), msk_y[k], msk_x[k])));
        end
        chk("mask_no_dest", 64'(o_ready_pci), 64'd0);
        tick();
        chk("mask_no_dest_hold", 64'(o_ready_pci), 64'd0);

        // Reset with packets outstanding; returns during reset are dropped
        i_pe_en = 4'hF; rstn = 1'b0;
        i_valid_pe = 1'b1; i_data_pe = mk(32'hEE, 3'd0, 1'b1, 1'b0);
        tick();
        chk("rst2_o_valid", 64'(o_valid), 64'd0);
        chk("rst2_o_data", 64'(o_data), 64'd0);
        chk("rst2_o_valid_pci", 64'(o_valid_pci), 64'd0);
        chk("rst2_o_data_pci", 64'(o_data_pci), 64'd0);
        chk("rst2_o_ready_pci", 64'(o_ready_pci), 64'd0);
        chk("rst2_o_ready_pe", 64'(o_ready_pe), 64'd0);
        tick();
        rstn = 1'b1; i_valid_pe = 1'b0; i_valid_pci = 1'b0;
        tick(); chk("rst2_no_egress_a", 64'(o_valid_pci), 64'd0);
        tick(); chk("rst2_no_egress_b", 64'(o_valid_pci), 64'd0);
        i_valid_pci = 1'b1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            i_data_pci = 32'hF0 + 32'(acc);
            if (o_ready_pci) acc++;
            tick();
        end
        chk("rst2_credits", 64'(acc), 64'd8);
        i_valid_pci = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
